shift_sequencer: RTL and testbench

//  Multi-cycle controller for the combinational 8-bit barrel shifter (shifter8bit: s[2:0], a[7:0], lr, y).

---
 rtl/shift_sequencer.sv | 114 +++++++++++
 tb/tb_shift_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle sequencer around an external combinational 8-bit barrel shifter.
// Chains shifter passes for long logical shifts, and builds rotates from two passes combined with OR.
module shift_sequencer #(
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_data,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             req_lr,
    input  logic             req_rot,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic [2:0]       sh_s,
    output logic [7:0]       sh_a,
    output logic             sh_lr,
    input  logic [7:0]       sh_y
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROT2, DONE} state_t;

    state_t           state;
    logic [7:0]       acc;
    logic [7:0]       src;
    logic [AMT_W-1:0] rem;
    logic             dir;
    logic             rot;

    logic [2:0]       step;
    logic [AMT_W-1:0] rem_next;
    logic             req_zero;

    // One pass of the shifter covers at most 7 positions.
    assign step     = (rem > AMT_W'(7)) ? 3'd7 : rem[2:0];
    assign rem_next = rem - AMT_W'(step);
    assign req_zero = req_rot ? (req_amt[2:0] == 3'd0) : (req_amt == '0);

    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == DONE);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        sh_s  = 3'd0;
        sh_a  = acc;
        sh_lr = dir;
        case (state)
            SHIFT: sh_s = step;
            ROT2: begin
                // Complementary pass: 8-k equals -k modulo 8.
                sh_s  = 3'd0 - rem[2:0];
                sh_a  = src;
                sh_lr = ~dir;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; the reset is synchronous to clk.
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            src      <= '0;
            rem      <= '0;
            dir      <= 1'b0;
            rot      <= 1'b0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        src <= req_data;
                        acc <= req_data;
                        dir <= req_lr;
                        rot <= req_rot;
                        rem <= req_rot ? AMT_W'(req_amt[2:0]) : req_amt;
                        if (req_zero) begin
                            state    <= DONE;
                            rsp_data <= req_data;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= sh_y;
                    if (rot) begin
                        state <= ROT2;
                    end else begin
                        rem <= rem_next;
                        // Once the byte is all zeros further passes cannot change it.
                        if (rem_next == '0 || sh_y == 8'h00) begin
                            state    <= DONE;
                            rsp_data <= sh_y;
                        end
                    end
                end
                ROT2: begin
                    acc      <= acc | sh_y;
                    rsp_data <= acc | sh_y;
                    state    <= DONE;
                end
                DONE: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed table, multi-cycle corner sequences,
// and random requests compared against a shift/rotate reference model.
module tb_shift_sequencer;

    localparam int AMT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_data;
    logic [AMT_W-1:0] req_amt;
    logic             req_lr;
    logic             req_rot;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic [2:0]       sh_s;
    logic [7:0]       sh_a;
    logic             sh_lr;
    logic [7:0]       sh_y;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] got;
    int         lat;
    int         passes;

    always #5 clk = ~clk;

    // Model of the combinational barrel shifter the sequencer drives.
    assign sh_y = sh_lr ? (sh_a >> sh_s) : (sh_a << sh_s);

    shift_sequencer #(.AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_lr    (req_lr),
        .req_rot   (req_rot),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .sh_s      (sh_s),
        .sh_a      (sh_a),
        .sh_lr     (sh_lr),
        .sh_y      (sh_y)
    );

    typedef struct {
        logic [7:0] d;
        int         amt;
        logic       lr;
        logic       rot;
        logic [7:0] exp;
        int         lat;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] shifted(input logic [7:0] d, input int n, input logic lr);
        if (n >= 8) return 8'h00;
        return lr ? (d >> n) : (d << n);
    endfunction

    function automatic logic [7:0] ref_result(input logic [7:0] d, input int amt, input logic lr, input logic rot);
        int v;
        int k;
        v = d;
        if (!rot) return shifted(d, amt, lr);
        k = amt % 8;
        if (lr) return 8'(((v >> k) | (v << (8 - k))) & 255);
        return 8'(((v << k) | (v >> (8 - k))) & 255);
    endfunction

    function automatic int ref_passes(input logic [7:0] d, input int amt, input logic lr, input logic rot);
        int done_amt;
        int p;
        if (rot) return ((amt % 8) == 0) ? 0 : 2;
        if (amt == 0) return 0;
        done_amt = 0;
        for (p = 1; p <= 8; p++) begin
            done_amt = (done_amt + 7 > amt) ? amt : done_amt + 7;
            if (done_amt == amt || shifted(d, done_amt, lr) == 8'h00) return p;
        end
        return p;
    endfunction

    // Issue one request, wait for the response, then consume it.
    task automatic run(input logic [7:0] d, input int amt, input logic lr, input logic rot,
                       output logic [7:0] res, output int l, output int p);
        check("req_ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = AMT_W'(amt);
        req_lr    = lr;
        req_rot   = rot;
        tick;
        req_valid = 1'b0;
        req_data  = 8'($urandom);
        req_amt   = AMT_W'($urandom);
        req_lr    = 1'($urandom);
        req_rot   = 1'($urandom);
        l = 1;
        p = 0;
        while (!rsp_valid && l < 64) begin
            if (sh_s != 3'd0) p++;
            tick;
            l++;
        end
        check("rsp_valid_arrives", rsp_valid, 1);
        res = rsp_data;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'h24,  3, 1'b0, 1'b0, 8'h20, 2};
        tbl[1] = '{8'hF0, 12, 1'b1, 1'b0, 8'h00, 3};
        tbl[2] = '{8'h01, 20, 1'b0, 1'b0, 8'h00, 3};
        tbl[3] = '{8'h24,  3, 1'b0, 1'b1, 8'h21, 3};
        tbl[4] = '{8'h24, 11, 1'b0, 1'b1, 8'h21, 3};
        tbl[5] = '{8'h81,  1, 1'b1, 1'b1, 8'hC0, 3};
        tbl[6] = '{8'h5A,  0, 1'b0, 1'b0, 8'h5A, 1};
        tbl[7] = '{8'hA5,  8, 1'b1, 1'b1, 8'hA5, 1};
        tbl[8] = '{8'hFF, 31, 1'b1, 1'b0, 8'h00, 3};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_data  = 8'h00;
        req_amt   = '0;
        req_lr    = 1'b0;
        req_rot   = 1'b0;
        rsp_ready = 1'b0;
        tick;
        tick;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 8'h00);
        check("reset_sh_s", sh_s, 3'd0);
        check("reset_sh_a", sh_a, 8'h00);
        check("reset_sh_lr", sh_lr, 0);
        check("reset_req_ready", req_ready, 0);
        rst = 1'b0;
        #1;
        check("idle_req_ready", req_ready, 1);
        tick;

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            run(tbl[i].d, tbl[i].amt, tbl[i].lr, tbl[i].rot, got, lat, passes);
            check($sformatf("tbl%0d_data", i), got, tbl[i].exp);
            check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
        end

        // Pass trace: right shift 0xF0 by 12 -> s=7 then s=5.
        req_valid = 1'b1; req_data = 8'hF0; req_amt = AMT_W'(12); req_lr = 1'b1; req_rot = 1'b0;
        tick;
        req_valid = 1'b0;
        check("trace12_p1_s", sh_s, 3'd7);
        check("trace12_p1_a", sh_a, 8'hF0);
        check("trace12_p1_lr", sh_lr, 1);
        tick;
        check("trace12_p2_s", sh_s, 3'd5);
        check("trace12_p2_a", sh_a, 8'h01);
        tick;
        check("trace12_valid", rsp_valid, 1);
        check("trace12_data", rsp_data, 8'h00);
        check("trace12_idle_s", sh_s, 3'd0);
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;

        // Pass trace: rotate left 0x24 by 11 -> (s=3,lr=0) then (s=5,lr=1).
        req_valid = 1'b1; req_data = 8'h24; req_amt = AMT_W'(11); req_lr = 1'b0; req_rot = 1'b1;
        tick;
        req_valid = 1'b0;
        check("rot11_p1_s", sh_s, 3'd3);
        check("rot11_p1_lr", sh_lr, 0);
        tick;
        check("rot11_p2_s", sh_s, 3'd5);
        check("rot11_p2_lr", sh_lr, 1);
        check("rot11_p2_a", sh_a, 8'h24);
        tick;
        check("rot11_data", rsp_data, 8'h21);

        // Backpressure: response held while rsp_ready is low; new requests refused.
        req_valid = 1'b1; req_data = 8'h77; req_amt = AMT_W'(2); req_lr = 1'b0; req_rot = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, 8'h21);
            check("bp_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("bp_release_valid", rsp_valid, 0);
        check("bp_release_ready", req_ready, 1);

        // Reset during a multi-pass shift discards the transaction.
        req_valid = 1'b1; req_data = 8'h01; req_amt = AMT_W'(20); req_lr = 1'b0; req_rot = 1'b0;
        tick;
        req_valid = 1'b0;
        check("rst_mid_shift_s", sh_s, 3'd7);
        rst = 1'b1;
        tick;
        check("rst_mid_valid", rsp_valid, 0);
        check("rst_mid_sh_s", sh_s, 3'd0);
        check("rst_mid_sh_a", sh_a, 8'h00);
        check("rst_mid_req_ready", req_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_mid_idle_ready", req_ready, 1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("rst_mid_no_rsp", rsp_valid, 0);
        end
        rsp_ready = 1'b0;

        // Random requests against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] d;
            int         amt;
            logic       lr;
            logic       rot;
            d   = 8'($urandom);
            amt = $urandom_range(0, (1 << AMT_W) - 1);
            lr  = 1'($urandom);
            rot = 1'($urandom);
            if ($urandom_range(0, 3) == 0) d = 8'h01 << $urandom_range(0, 7);
            run(d, amt, lr, rot, got, lat, passes);
            check($sformatf("rnd%0d_data", i), got, ref_result(d, amt, lr, rot));
            check($sformatf("rnd%0d_passes", i), passes, ref_passes(d, amt, lr, rot));
            check($sformatf("rnd%0d_latency", i), lat, ref_passes(d, amt, lr, rot) + 1);
            if ($urandom_range(0, 1) == 1) tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
